// File: rtl/u_norm_seq.sv
// u_norm_seq: sequential P/NP-class truth-table canonicaliser.
// Walks every (perm, mask) candidate and keeps the minimum {g,P,M} key.
module u_norm_seq #(
  parameter int N      = 4,
  parameter int NEG_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [(1<<N)-1:0]        in_func,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1<<N)-1:0]        out_norm,
  output logic [N*$clog2(N)-1:0]   out_perm,
  output logic [N-1:0]             out_neg
);

  localparam int TT_W = 1 << N;
  localparam int IW   = $clog2(N);
  localparam int PW   = N * IW;
  localparam int KW   = TT_W + PW + N;

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  localparam int C  = fact(N) * ((NEG_EN != 0) ? TT_W : 1);
  localparam int CW = $clog2(C + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [TT_W-1:0] func_r;
  logic [IW-1:0]   dig [N];
  logic [IW-1:0]   dig_n [N];
  logic [N-1:0]    msk;
  logic [N-1:0]    msk_n;
  logic [CW-1:0]   cyc;
  logic            carry;

  logic [IW-1:0]   perm [N];
  logic [N-1:0]    used;
  logic [IW:0]     pick;
  logic [PW-1:0]   perm_flat;

  logic [TT_W-1:0] g;
  logic [N-1:0]    yv;
  logic [N-1:0]    xi;

  logic [KW-1:0]   cand_key;
  logic [KW-1:0]   cand;
  logic [KW-1:0]   best;
  logic [KW-1:0]   merged;
  logic            cand_vld;
  logic            best_vld;

  logic            accept;
  logic            last;

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign last      = (state == RUN) && (cyc == CW'(C));
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state; flush overrides every other transition.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Lehmer digits -> permutation: slot k takes the dig[k]-th unused input.
  always_comb begin
    used = '0;
    pick = '0;
    for (int k = 0; k < N; k++) begin
      perm[k] = '0;
      pick    = '0;
      for (int i = 0; i < N; i++) begin
        if (!used[i]) begin
          if (pick == {1'b0, dig[k]}) perm[k] = IW'(i);
          pick = pick + (IW+1)'(1);
        end
      end
      used[perm[k]] = 1'b1;
    end
  end

  // Pack permutation fields, slot 0 in the MSB field.
  always_comb begin
    perm_flat = '0;
    for (int k = 0; k < N; k++)
      perm_flat[(N-1-k)*IW +: IW] = perm[k];
  end

  // Transformed table: g(y) = f(x) with x[P[k]] = y[k] ^ M[k].
  always_comb begin
    g  = '0;
    yv = '0;
    xi = '0;
    for (int y = 0; y < TT_W; y++) begin
      yv = N'(y);
      xi = '0;
      for (int k = 0; k < N; k++)
        xi[N-1-int'(perm[k])] = yv[N-1-k] ^ msk[N-1-k];
      g[TT_W-1-y] = func_r[TT_W-1-int'(xi)];
    end
  end

  assign cand_key = {g, perm_flat, msk};

  // Mask is the inner counter; digits form a mixed-radix outer counter.
  always_comb begin
    msk_n = msk;
    dig_n = dig;
    carry = 1'b1;
    if (NEG_EN != 0) begin
      msk_n = msk + N'(1);
      carry = &msk;
    end
    for (int k = N - 2; k >= 0; k--) begin
      if (carry) begin
        if (dig[k] == IW'(N - 1 - k)) begin
          dig_n[k] = '0;
        end else begin
          dig_n[k] = dig[k] + IW'(1);
          carry    = 1'b0;
        end
      end
    end
  end

  // Running minimum including the candidate staged last cycle.
  always_comb begin
    merged = best;
    if (cand_vld && (!best_vld || cand_key_lt())) merged = cand;
  end

  function automatic logic cand_key_lt();
    return cand < best;
  endfunction

  // Candidate staging, minimum tracking and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_r   <= '0;
      dig      <= '{default: '0};
      msk      <= '0;
      cyc      <= '0;
      cand     <= '0;
      best     <= '0;
      cand_vld <= 1'b0;
      best_vld <= 1'b0;
      out_norm <= '0;
      out_perm <= '0;
      out_neg  <= '0;
    end else if (accept) begin
      func_r   <= in_func;
      dig      <= '{default: '0};
      msk      <= '0;
      cyc      <= '0;
      cand_vld <= 1'b0;
      best_vld <= 1'b0;
    end else if (state == RUN && !flush) begin
      if (cyc != CW'(C)) begin
        cand <= cand_key;
        dig  <= dig_n;
        msk  <= msk_n;
        cyc  <= cyc + CW'(1);
      end
      cand_vld <= (cyc != CW'(C));
      if (cand_vld) begin
        best     <= merged;
        best_vld <= 1'b1;
      end
      if (last) begin
        out_norm <= merged[KW-1 -: TT_W];
        out_perm <= merged[N +: PW];
        out_neg  <= merged[N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_u_norm_seq.sv
// Bench for u_norm_seq: four parameterisations driven one at a time,
// results checked against a brute-force canonicaliser via a scoreboard.
module tb_u_norm_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  iv;
  logic [3:0]  fl;
  logic [3:0]  orr;
  logic [31:0] fn [4];
  wire  [3:0]  ir;
  wire  [3:0]  ov;
  wire  [63:0] key [4];

  wire [15:0] a_norm, b_norm;
  wire [7:0]  a_perm, b_perm;
  wire [3:0]  a_neg,  b_neg;
  wire [7:0]  c_norm;
  wire [5:0]  c_perm;
  wire [2:0]  c_neg;
  wire [31:0] d_norm;
  wire [14:0] d_perm;
  wire [4:0]  d_neg;

  u_norm_seq #(.N(4), .NEG_EN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_func(fn[0][15:0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_ready(orr[0]), .out_norm(a_norm), .out_perm(a_perm),
    .out_neg(a_neg));
  u_norm_seq #(.N(4), .NEG_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_func(fn[1][15:0]), .flush(fl[1]), .out_valid(ov[1]),
    .out_ready(orr[1]), .out_norm(b_norm), .out_perm(b_perm),
    .out_neg(b_neg));
  u_norm_seq #(.N(3), .NEG_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_func(fn[2][7:0]), .flush(fl[2]), .out_valid(ov[2]),
    .out_ready(orr[2]), .out_norm(c_norm), .out_perm(c_perm),
    .out_neg(c_neg));
  u_norm_seq #(.N(5), .NEG_EN(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_func(fn[3]), .flush(fl[3]), .out_valid(ov[3]),
    .out_ready(orr[3]), .out_norm(d_norm), .out_perm(d_perm),
    .out_neg(d_neg));

  assign key[0] = 64'({a_norm, a_perm, a_neg});
  assign key[1] = 64'({b_norm, b_perm, b_neg});
  assign key[2] = 64'({c_norm, c_perm, c_neg});
  assign key[3] = 64'({d_norm, d_perm, d_neg});

  typedef struct {
    int          d;
    logic [63:0] key;
    int          t0;
  } sb_t;
  sb_t sbq[$];

  function automatic int nin(input int d);
    case (d)
      0, 1: return 4;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  function automatic bit negen(input int d);
    return (d == 1 || d == 2);
  endfunction

  function automatic int lat(input int d);
    case (d)
      0: return 25;
      1: return 385;
      2: return 49;
      default: return 121;
    endcase
  endfunction

  // Brute force: every n-tuple of indices, keep only permutations.
  function automatic logic [63:0] canon(input int n, input bit ng,
                                        input logic [31:0] f);
    int tw, iw, lim, c, x, pc;
    int p [5];
    bit ok;
    logic [4:0] seen;
    logic [31:0] gg;
    logic [63:0] best, k64;
    tw = 1 << n;
    iw = (n <= 2) ? 1 : (n <= 4) ? 2 : 3;
    lim = 1;
    for (int i = 0; i < n; i++) lim = lim * n;
    best = '1;
    for (int code = 0; code < lim; code++) begin
      c = code;
      seen = '0;
      ok = 1'b1;
      for (int k = 0; k < n; k++) begin
        p[k] = c % n;
        c = c / n;
        if (seen[p[k]]) ok = 1'b0;
        seen[p[k]] = 1'b1;
      end
      if (!ok) continue;
      pc = 0;
      for (int k = 0; k < n; k++) pc = (pc << iw) | p[k];
      for (int m = 0; m < (ng ? tw : 1); m++) begin
        gg = '0;
        for (int y = 0; y < tw; y++) begin
          x = 0;
          for (int k = 0; k < n; k++)
            if ((((y >> (n-1-k)) ^ (m >> (n-1-k))) & 1) != 0)
              x = x | (1 << (n-1-p[k]));
          if (f[tw-1-x]) gg[tw-1-y] = 1'b1;
        end
        k64 = (64'(gg) << (iw*n + n)) | (64'(pc) << n) | 64'(m);
        if (k64 < best) best = k64;
      end
    end
    return best;
  endfunction

  task automatic accept(input int d, input logic [31:0] f,
                        output int t0, output bit ok);
    @(negedge clk);
    fn[d] = f;
    iv[d] = 1'b1;
    ok = 1'b0;
    t0 = 0;
    for (int i = 0; i < 50; i++) begin
      if (ir[d]) begin
        t0 = edges + 1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int t1, output bit ok);
    ok = 1'b0;
    t1 = 0;
    for (int i = 0; i < 5000; i++) begin
      if (ov[d]) begin
        t1 = edges;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = '0;
    fl = '0;
    orr = '1;
    for (int d = 0; d < 4; d++) fn[d] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || key[d] !== 64'd0) begin
        n_bad++;
        $display("FAIL reset_state dut=%0d ov=%b ir=%b key=%h want 0 1 0",
                 d, ov[d], ir[d], key[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ir !== 4'hF || ov !== 4'h0) begin
      n_bad++;
      $display("FAIL post_reset ir=%b ov=%b want 1111 0000", ir, ov);
    end
  endtask

  task automatic test_transfer(input int d, input logic [31:0] f,
                               input logic [63:0] exp, input string tag);
    int t0, t1;
    bit ok;
    sb_t e;
    accept(d, f, t0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s accept in_ready=0 want 1", tag);
      return;
    end
    sbq.push_back('{d, exp, t0});
    wait_out(d, t1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s out_valid timeout got 0 want 1", tag);
      sbq.delete();
      return;
    end
    e = sbq.pop_front();
    n_cmp++;
    if (key[e.d] !== e.key) begin
      n_bad++;
      $display("FAIL %s result got %h want %h", tag, key[e.d], e.key);
    end
    n_cmp++;
    if (t1 - e.t0 != lat(d)) begin
      n_bad++;
      $display("FAIL %s latency got %0d want %0d", tag, t1 - e.t0, lat(d));
    end
    @(negedge clk);
    n_cmp++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s handoff ov=%b ir=%b want 0 1", tag, ov[d], ir[d]);
    end
  endtask

  task automatic test_p_class();
    test_transfer(0, 32'h0001, {36'd0, 16'h0001, 8'h1B, 4'h0}, "and4");
    test_transfer(0, 32'h5555, {36'd0, 16'h00FF, 8'hC6, 4'h0}, "in3");
    test_transfer(0, 32'h00FF, {36'd0, 16'h00FF, 8'h1B, 4'h0}, "in0");
  endtask

  task automatic test_np_class();
    test_transfer(1, 32'hFF00, {36'd0, 16'h00FF, 8'h1B, 4'b1000}, "ninv0");
    test_transfer(1, 32'h0000, {36'd0, 16'h0000, 8'h1B, 4'h0}, "const0");
  endtask

  task automatic test_backpressure();
    int t0, t1;
    bit ok;
    bit seen;
    sb_t e;
    orr[0] = 1'b0;
    accept(0, 32'h5555, t0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp accept in_ready=0 want 1");
      orr[0] = 1'b1;
      return;
    end
    sbq.push_back('{0, {36'd0, 16'h00FF, 8'hC6, 4'h0}, t0});
    wait_out(0, t1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp out_valid timeout got 0 want 1");
      orr[0] = 1'b1;
      sbq.delete();
      return;
    end
    e = sbq.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      fn[0] = 32'h0001;
      n_cmp++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || key[0] !== e.key) begin
        n_bad++;
        $display("FAIL bp_hold cyc=%0d ov=%b ir=%b key=%h want 1 0 %h",
                 i, ov[0], ir[0], key[0], e.key);
      end
    end
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release ov=%b ir=%b want 0 1", ov[0], ir[0]);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0] || !ir[0]) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL bp_ignored busy request got 1 want 0");
    end
  endtask

  task automatic test_flush();
    int t0;
    bit ok;
    bit seen;
    accept(0, 32'h0001, t0, ok);
    repeat (9) @(negedge clk);
    fl[0] = 1'b1;
    #1;
    n_cmp++;
    if (!ok || ir[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready ok=%b ir=%b want 1 0", ok, ir[0]);
    end
    @(negedge clk);
    fl[0] = 1'b0;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_idle ov=%b ir=%b want 0 1", ov[0], ir[0]);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL flush_noout out_valid got 1 want 0");
    end
    test_transfer(0, 32'h00FF, {36'd0, 16'h00FF, 8'h1B, 4'h0}, "post_flush");
  endtask

  task automatic test_reset_mid_run();
    int t0;
    bit ok;
    bit seen;
    accept(1, 32'h5555, t0, ok);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || ov[1] !== 1'b0 || ir[1] !== 1'b1 || key[1] !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_mid ok=%b ov=%b ir=%b key=%h want 1 0 1 0",
               ok, ov[1], ir[1], key[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (420) begin
      @(negedge clk);
      if (ov[1]) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_noout out_valid got 1 want 0");
    end
    test_transfer(1, 32'hFF00, {36'd0, 16'h00FF, 8'h1B, 4'b1000}, "post_rst");
  endtask

  task automatic test_random();
    logic [31:0] f;
    logic [31:0] m;
    int n;
    for (int d = 0; d < 4; d++) begin
      n = nin(d);
      m = (n == 5) ? 32'hFFFF_FFFF : ((32'd1 << (1 << n)) - 32'd1);
      for (int r = 0; r < 3; r++) begin
        f = $urandom() & m;
        test_transfer(d, f, canon(n, negen(d), f), $sformatf("rnd%0d_%0d", d, r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_p_class();
    test_np_class();
    test_backpressure();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
